// File: rtl/mlp_pkg.sv
// mlp_pkg: shared types and fixed-point helpers for mlp_seq; MLP_SEQ_SAT_EN selects saturating requant
package mlp_pkg;
    typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;
    typedef logic signed [63:0] wide_t;
    function automatic int acc_width(int dw, int n_in, int n_hid);
        return 2 * dw + $clog2((n_in > n_hid ? n_in : n_hid) + 1);
    endfunction
    function automatic wide_t requant(wide_t acc, int dw, int shift);
        wide_t sh = acc >>> shift;
`ifdef MLP_SEQ_SAT_EN
        wide_t hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        wide_t lo = -(64'sd1 <<< (dw - 1));
        return sh > hi ? hi : (sh < lo ? lo : sh);
`else
        // keep only the low dw bits, sign-extended, so relu sees the wrapped value
        return (sh <<< (64 - dw)) >>> (64 - dw);
`endif
    endfunction
    function automatic wide_t relu(wide_t x);
        return x < 0 ? '0 : x;
    endfunction
endpackage

// File: rtl/mlp_mac.sv
// mlp_mac: registered signed multiply-accumulate; load restarts the sum from a sign-extended bias
module mlp_mac #(
    parameter int DW = 8,
    parameter int AW = 20
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 en,
    input  logic                 load,
    input  logic signed [DW-1:0] bias,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [AW-1:0] acc_next
);
    logic signed [AW-1:0]   acc;
    logic signed [2*DW-1:0] prod;
    assign prod     = a * b;
    assign acc_next = (load ? AW'(bias) : acc) + AW'(prod);
    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) acc <= '0;
        else if (en) acc <= acc_next;
endmodule

// File: rtl/mlp_seq.sv
// mlp_seq: time-multiplexed two-layer MLP (ReLU hidden layer) on one MAC, valid/ready in and out.
// Build option MLP_SEQ_SAT_EN: saturating requant; otherwise results wrap to DW bits.
module mlp_seq
    import mlp_pkg::*;
#(
    parameter int DW    = 8,
    parameter int N_IN  = 6,
    parameter int N_HID = 16,
    parameter int N_OUT = 3,
    parameter int SHIFT = 0
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [N_IN*DW-1:0]          din_i,
    input  logic [N_IN*N_HID*DW-1:0]    w1_i,
    input  logic [N_HID*DW-1:0]         b1_i,
    input  logic [N_HID*N_OUT*DW-1:0]   w2_i,
    input  logic [N_OUT*DW-1:0]         b2_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [N_OUT*DW-1:0]         dout_o,
    output logic                        busy_o
);
    localparam int ACC_W = acc_width(DW, N_IN, N_HID);
    localparam int MX0   = N_IN > N_HID ? N_IN : N_HID;
    localparam int MX    = MX0 > N_OUT ? MX0 : N_OUT;
    localparam int IW    = $clog2(MX + 1);

    state_t               state, state_nxt;
    logic [IW-1:0]        k, n;
    logic signed [DW-1:0] din_r [N_IN];
    logic signed [DW-1:0] h [N_HID];
    logic signed [DW-1:0] y [N_OUT];
    logic signed [DW-1:0] op_a, op_b, op_bias, rq, hq;
    logic signed [ACC_W-1:0] acc_next;
    logic                 step, last_k, last_n;

    always_comb begin
        step       = state == L1 || state == L2;
        last_k     = state == L1 ? k == IW'(N_IN - 1) : k == IW'(N_HID - 1);
        last_n     = state == L1 ? n == IW'(N_HID - 1) : n == IW'(N_OUT - 1);
        in_ready_o = state == IDLE;
        busy_o     = state != IDLE;
        state_nxt  = state == IDLE ? (in_valid_i ? L1 : IDLE) :
                     state == DONE ? ((out_valid_o && out_ready_i) ? IDLE : DONE) :
                     (last_k && last_n) ? (state == L1 ? L2 : DONE) : state;
    end

    // operand selection: layer 1 reads the captured input, layer 2 the hidden buffer
    always_comb begin
        op_a    = '0;
        op_b    = '0;
        op_bias = '0;
        for (int i = 0; i < N_IN; i++)
            if (state == L1 && k == IW'(i)) op_a = din_r[i];
        for (int i = 0; i < N_HID; i++)
            if (state == L2 && k == IW'(i)) op_a = h[i];
        for (int i = 0; i < N_IN; i++)
            for (int j = 0; j < N_HID; j++)
                if (state == L1 && k == IW'(i) && n == IW'(j)) op_b = w1_i[(i*N_HID+j)*DW +: DW];
        for (int i = 0; i < N_HID; i++)
            for (int j = 0; j < N_OUT; j++)
                if (state == L2 && k == IW'(i) && n == IW'(j)) op_b = w2_i[(i*N_OUT+j)*DW +: DW];
        for (int j = 0; j < N_HID; j++)
            if (state == L1 && n == IW'(j)) op_bias = b1_i[j*DW +: DW];
        for (int j = 0; j < N_OUT; j++)
            if (state == L2 && n == IW'(j)) op_bias = b2_i[j*DW +: DW];
    end

    mlp_mac #(.DW(DW), .AW(ACC_W)) u_mac (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .en       (step),
        .load     (k == '0),
        .bias     (op_bias),
        .a        (op_a),
        .b        (op_b),
        .acc_next (acc_next)
    );

    assign rq = DW'(requant(64'(acc_next), DW, SHIFT));
    assign hq = DW'(relu(requant(64'(acc_next), DW, SHIFT)));

    always_ff @(posedge clk_i or negedge rstn_i)
        if (!rstn_i) begin
            state       <= IDLE;
            k           <= '0;
            n           <= '0;
            out_valid_o <= 1'b0;
            dout_o      <= '0;
        end else begin
            state <= state_nxt;
            if (step) begin
                k <= last_k ? '0 : k + 1'b1;
                if (last_k) n <= last_n ? '0 : n + 1'b1;
            end
            // first DONE cycle publishes the result, later cycles wait for the consumer
            if (state == DONE) begin
                if (!out_valid_o) begin
                    out_valid_o <= 1'b1;
                    for (int j = 0; j < N_OUT; j++) dout_o[j*DW +: DW] <= y[j];
                end else if (out_ready_i) out_valid_o <= 1'b0;
            end
        end

    always_ff @(posedge clk_i) begin
        if (in_valid_i && state == IDLE)
            for (int i = 0; i < N_IN; i++) din_r[i] <= din_i[i*DW +: DW];
        for (int i = 0; i < N_HID; i++)
            if (state == L1 && last_k && n == IW'(i)) h[i] <= hq;
        for (int j = 0; j < N_OUT; j++)
            if (state == L2 && last_k && n == IW'(j)) y[j] <= rq;
    end
endmodule

// File: tb/tb_mlp_seq.sv
// tb_mlp_seq: directed checks of mlp_seq at SHIFT=0 and SHIFT=2 against hand-computed results
module tb_mlp_seq;
    localparam int DW = 8, N_IN = 6, N_HID = 16, N_OUT = 3, LAT = N_HID*N_IN + N_OUT*N_HID + 1;

    logic clk_i = 1'b0, rstn_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [N_IN*DW-1:0]        din_i;
    logic [N_IN*N_HID*DW-1:0]  w1_i;
    logic [N_HID*DW-1:0]       b1_i;
    logic [N_HID*N_OUT*DW-1:0] w2_i;
    logic [N_OUT*DW-1:0]       b2_i;
    logic                      in_ready_o, out_valid_o, busy_o, in_ready_s, out_valid_s, busy_s;
    logic [N_OUT*DW-1:0]       dout_o, dout_s;
    int vectors = 0, miscompares = 0, lat;

    always #5 clk_i = ~clk_i;

    mlp_seq #(.DW(DW), .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .SHIFT(0)) u_dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .din_i(din_i), .w1_i(w1_i), .b1_i(b1_i), .w2_i(w2_i), .b2_i(b2_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .dout_o(dout_o), .busy_o(busy_o));

    mlp_seq #(.DW(DW), .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .SHIFT(2)) u_dut_s (
        .clk_i(clk_i), .rstn_i(rstn_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_s),
        .din_i(din_i), .w1_i(w1_i), .b1_i(b1_i), .w2_i(w2_i), .b2_i(b2_i),
        .out_valid_o(out_valid_s), .out_ready_i(out_ready_i), .dout_o(dout_s), .busy_o(busy_s));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N_OUT*DW-1:0] rep(input int v);
        logic [DW-1:0] t = v[DW-1:0];
        return {t, t, t};
    endfunction

    task automatic load(input int w1, input int b1, input int w2, input int b2, input int d);
        for (int i = 0; i < N_IN; i++) din_i[i*DW +: DW] = d[DW-1:0];
        for (int i = 0; i < N_IN*N_HID; i++) w1_i[i*DW +: DW] = w1[DW-1:0];
        for (int i = 0; i < N_HID; i++) b1_i[i*DW +: DW] = b1[DW-1:0];
        for (int i = 0; i < N_HID*N_OUT; i++) w2_i[i*DW +: DW] = w2[DW-1:0];
        for (int i = 0; i < N_OUT; i++) b2_i[i*DW +: DW] = b2[DW-1:0];
    endtask

    task automatic start();
        @(negedge clk_i);
        in_valid_i = 1'b1;
        @(posedge clk_i);
        #1 in_valid_i = 1'b0;
    endtask

    task automatic run(output int l);
        start();
        l = 0;
        while (l < 1000) begin
            @(posedge clk_i);
            l++;
            #1;
            if (out_valid_o) break;
        end
    endtask

    task automatic consume();
        @(negedge clk_i);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1 out_ready_i = 1'b0;
    endtask

    initial begin
        load(1, 0, 1, 0, 1);
        #1;
        check("rst_in_ready", in_ready_o, 1);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_dout", dout_o, 0);
        #11 rstn_i = 1'b1;

        run(lat);
        check("base_lat", lat, LAT);
        check("base_dout", dout_o, rep(96));
        check("base_busy", busy_o, 1);
        check("shift2_dout", dout_s, rep(4));
        check("shift2_valid", out_valid_s, 1);
        consume();

        load(127, 0, 127, 0, 127);
        run(lat);
`ifdef MLP_SEQ_SAT_EN
        check("sat_dout", dout_o, rep(127));
        check("sat_shift2_dout", dout_s, rep(127));
`else
        check("wrap_dout", dout_o, rep(-96));
        check("wrap_shift2_dout", dout_s, rep(0));
`endif
        consume();

        load(1, -10, 1, 0, 1);
        b2_i = {8'sd7, -8'sd3, 8'sd5};
        run(lat);
        check("relu_dout", dout_o, {8'd7, 8'hFD, 8'd5});
        check("relu_shift2_dout", dout_s, {8'd1, 8'hFF, 8'd1});
        consume();

        load(1, 0, -1, 0, 1);
        run(lat);
        check("neg_dout", dout_o, rep(-96));
        check("neg_shift2_dout", dout_s, rep(-4));
        consume();

        load(1, 0, 1, 0, 1);
        run(lat);
        in_valid_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk_i);
            #1;
            check("bp_valid", out_valid_o, 1);
            check("bp_dout", dout_o, rep(96));
            check("bp_in_ready", in_ready_o, 0);
        end
        in_valid_i = 1'b0;
        consume();
        check("rel_valid", out_valid_o, 0);
        check("rel_in_ready", in_ready_o, 1);
        check("rel_busy", busy_o, 0);
        @(posedge clk_i);
        #1 check("idle_stays", busy_o, 0);

        start();
        repeat (40) @(posedge clk_i);
        #2 rstn_i = 1'b0;
        #1;
        check("abort_in_ready", in_ready_o, 1);
        check("abort_valid", out_valid_o, 0);
        check("abort_busy", busy_o, 0);
        check("abort_dout", dout_o, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        run(lat);
        check("rerun_lat", lat, LAT);
        check("rerun_dout", dout_o, rep(96));
        check("rerun_shift2_dout", dout_s, rep(4));
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
